// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit adder that walks the operands one nibble per
// cycle through a single 4-bit carry-lookahead slice.
// Ports: clk, rst (sync, active-high), start, a, b, cin in;
//        busy, done (1-cycle pulse), sum, cout, ovf out (all registered).

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic [3:0] c,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;

  // c[i] is the carry into bit i, so c[3] is the carry into the slice MSB
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
  end
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NN = WIDTH / 4;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cy;
  logic [CW-1:0]    idx;

  logic [3:0] ss;
  logic [3:0] sc;
  logic       sco;

  // operands are shifted right so the active nibble is always [3:0]
  cla4_slice u_slice (
    .a    (opa[3:0]),
    .b    (opb[3:0]),
    .cin  (cy),
    .s    (ss),
    .c    (sc),
    .cout (sco)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cy    <= 1'b0;
      idx   <= '0;
      opa   <= '0;
      opb   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b;
            cy    <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          for (int k = 0; k < NN; k++) begin
            if (idx == CW'(k)) sum[4*k +: 4] <= ss;
          end
          cy  <= sco;
          opa <= opa >> 4;
          opb <= opb >> 4;
          idx <= idx + 1'b1;
          if (idx == CW'(NN - 1)) begin
            cout  <= sco;
            ovf   <= sc[3] ^ sco;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
